// File: rtl/seg_byte_decoder.sv
// seg_byte_decoder
//   Turns active-low 7-segment digit patterns back into nibbles and pairs a
//   low digit and a high digit into one byte. The byte is then held under a
//   valid/ready handshake. Malformed patterns and abandoned half-bytes raise
//   a one-cycle err pulse, and a saturating counter tallies those pulses.
//
//   Optional feature: define SEG_BLANK_AS_ZERO_EN to accept 7'h7F (all
//   segments dark, as used for leading-zero blanking) as nibble 0.
//
// Ports
//   clk         system clock, rising edge
//   resetn      synchronous active-low reset
//   seg_in      segment pattern {g,f,e,d,c,b,a}, active-low
//   seg_pos     0 = low nibble, 1 = high nibble
//   seg_valid   seg_in/seg_pos valid this cycle
//   seg_ready   digit accepted this cycle (low while a byte is held)
//   byte_out    assembled byte {hi, lo}
//   byte_valid  byte_out holds a completed byte
//   byte_ready  consumer takes byte_out
//   err         one-cycle pulse: invalid pattern or timeout
//   err_count   saturating count of err pulses
module seg_byte_decoder #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [6:0]           seg_in,
  input  logic                 seg_pos,
  input  logic                 seg_valid,
  output logic                 seg_ready,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {WAIT_LO, WAIT_HI, HOLD} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             lo_q, lo_d;
  logic [7:0]             byte_q, byte_d;
  logic                   bv_q, bv_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;

  logic                   pat_ok;
  logic [3:0]             pat_nib;
  logic                   xfer;

  // Pattern decode: purely combinational lookup of the 16 glyphs.
  always_comb begin
    pat_ok  = 1'b1;
    pat_nib = 4'h0;
    unique case (seg_in)
      7'h40: pat_nib = 4'h0;
      7'h79: pat_nib = 4'h1;
      7'h24: pat_nib = 4'h2;
      7'h30: pat_nib = 4'h3;
      7'h19: pat_nib = 4'h4;
      7'h12: pat_nib = 4'h5;
      7'h02: pat_nib = 4'h6;
      7'h78: pat_nib = 4'h7;
      7'h00: pat_nib = 4'h8;
      7'h10: pat_nib = 4'h9;
      7'h08: pat_nib = 4'hA;
      7'h03: pat_nib = 4'hB;
      7'h46: pat_nib = 4'hC;
      7'h21: pat_nib = 4'hD;
      7'h06: pat_nib = 4'hE;
      7'h0E: pat_nib = 4'hF;
`ifdef SEG_BLANK_AS_ZERO_EN
      7'h7F: pat_nib = 4'h0;
`endif
      default: pat_ok = 1'b0;
    endcase
  end

  assign seg_ready = (state_q != HOLD);
  assign xfer      = seg_valid & seg_ready;

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    byte_d  = byte_q;
    bv_d    = bv_q;
    err_d   = 1'b0;
    tcnt_d  = tcnt_q;

    unique case (state_q)
      WAIT_LO: begin
        if (xfer) begin
          if (seg_pos || !pat_ok) begin
            err_d = 1'b1;                 // high digit first, or bad glyph
          end else begin
            lo_d    = pat_nib;
            tcnt_d  = '0;
            state_d = WAIT_HI;
          end
        end
      end

      WAIT_HI: begin
        // A transfer on the final timeout cycle wins over the timeout.
        if (xfer) begin
          if (!pat_ok) begin
            err_d   = 1'b1;
            state_d = WAIT_LO;
          end else if (seg_pos) begin
            byte_d  = {pat_nib, lo_q};
            bv_d    = 1'b1;
            state_d = HOLD;
          end else begin
            lo_d   = pat_nib;             // newer low digit replaces the old
            tcnt_d = '0;
          end
        end else if (tcnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = WAIT_LO;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      HOLD: begin
        if (byte_ready) begin
          bv_d    = 1'b0;                 // byte_out keeps its last value
          state_d = WAIT_LO;
        end
      end

      default: state_d = WAIT_LO;
    endcase
  end

  // Counter moves on the same edge that raises err, and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (err_d && (cnt_q != '1)) cnt_d = cnt_q + ERR_CNT_W'(1);
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= WAIT_LO;
      lo_q    <= 4'h0;
      byte_q  <= 8'h00;
      bv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = bv_q;
  assign err        = err_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_seg_byte_decoder.sv
// Self-checking bench for seg_byte_decoder: directed steps from the test
// plan followed by randomized traffic, all compared against a transaction-
// level reference model that works on glyph indices and integer counters.
module tb_seg_byte_decoder;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [6:0] seg_in;
  logic       seg_pos;
  logic       seg_valid;
  logic       seg_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       err;
  logic [7:0] err_count;

  seg_byte_decoder #(.TIMEOUT_CYCLES(T), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .seg_in     (seg_in),
    .seg_pos    (seg_pos),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  logic [6:0] legal [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: is a byte held, pending low digit (-1 = none),
  // idle cycles spent waiting for the high digit, last byte, error tally.
  bit       m_hold;
  int       m_lo;
  int       m_idle;
  int       m_byte;
  bit       m_err;
  int       m_errcnt;

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (s == legal[i]) return i;
`ifdef SEG_BLANK_AS_ZERO_EN
    if (s == 7'h7F) return 0;
`endif
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs present at the
  // edge, then compare every output just after the edge.
  task automatic tick();
    int  d;
    bit  xf;
    d     = lookup(seg_in);
    m_err = 1'b0;
    if (!resetn) begin
      m_hold = 0; m_lo = -1; m_idle = 0; m_byte = 0; m_errcnt = 0;
    end else begin
      xf = seg_valid && !m_hold;
      if (m_hold) begin
        if (byte_ready) m_hold = 0;
      end else if (m_lo < 0) begin
        if (xf) begin
          if (seg_pos || d < 0) m_err = 1;
          else begin m_lo = d; m_idle = 0; end
        end
      end else if (xf) begin
        if (d < 0) begin
          m_err = 1; m_lo = -1;
        end else if (seg_pos) begin
          m_byte = d * 16 + m_lo; m_hold = 1; m_lo = -1;
        end else begin
          m_lo = d; m_idle = 0;
        end
      end else if (m_idle == T - 1) begin
        m_err = 1; m_lo = -1;
      end else begin
        m_idle++;
      end
      if (m_err && m_errcnt < 255) m_errcnt++;
    end
    @(posedge clk);
    #1;
    check("byte_out",   32'(byte_out),   32'(m_byte));
    check("byte_valid", 32'(byte_valid), 32'(m_hold));
    check("err",        32'(err),        32'(m_err));
    check("err_count",  32'(err_count),  32'(m_errcnt));
    check("seg_ready",  32'(seg_ready),  32'(!m_hold));
  endtask

  task automatic send(input logic [6:0] s, input logic p);
    seg_in = s; seg_pos = p; seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    resetn = 1'b0; seg_in = 7'h7F; seg_pos = 1'b0; seg_valid = 1'b0; byte_ready = 1'b0;
    m_hold = 0; m_lo = -1; m_idle = 0; m_byte = 0; m_err = 0; m_errcnt = 0;

    // Reset state
    tick();
    resetn = 1'b1;
    check("rst_seg_ready", 32'(seg_ready), 32'd1);

    // lo=79, hi=40 -> 01, held while byte_ready low; digits ignored in HOLD
    send(7'h79, 1'b0);
    send(7'h40, 1'b1);
    check("byte_01", 32'(byte_out), 32'h01);
    seg_in = 7'h55; seg_valid = 1'b1;
    idle(5);
    seg_valid = 1'b0;
    check("hold_ready_low", 32'(seg_ready), 32'd0);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    check("release_valid", 32'(byte_valid), 32'd0);

    // lo=10, lo=06 (overwrite), hi=0E -> FE, no err
    send(7'h10, 1'b0);
    send(7'h06, 1'b0);
    send(7'h0E, 1'b1);
    check("byte_FE", 32'(byte_out), 32'hFE);
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;

    // Blank pattern in the high position
    send(7'h40, 1'b0);
    send(7'h7F, 1'b1);
`ifdef SEG_BLANK_AS_ZERO_EN
    check("blank_byte", 32'(byte_out), 32'h00);
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
`else
    check("blank_err", 32'(err), 32'd1);
    check("blank_cnt", 32'(err_count), 32'd1);
`endif
    send(7'h79, 1'b0);
    check("after_blank_ready", 32'(seg_ready), 32'd1);

    // Timeout: lo then idle T cycles, then a stray high digit
    send(7'h24, 1'b0);
    idle(T - 1);
    check("no_early_timeout", 32'(err), 32'd0);
    tick();
    check("timeout_err", 32'(err), 32'd1);
    tick();
    check("timeout_pulse_once", 32'(err), 32'd0);
    send(7'h40, 1'b1);
    check("stray_hi_err", 32'(err), 32'd1);

    // Transfer on the timeout cycle wins over the timeout
    send(7'h24, 1'b0);
    idle(T - 1);
    send(7'h19, 1'b1);
    check("late_hi_byte", 32'(byte_out), 32'h42);
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) send(7'h55, 1'b0);
    check("err_sat", 32'(err_count), 32'hFF);

    // Reset while holding A5
    send(7'h12, 1'b0);
    send(7'h08, 1'b1);
    check("byte_A5", 32'(byte_out), 32'hA5);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("rst_hold_bv",  32'(byte_valid), 32'd0);
    check("rst_hold_out", 32'(byte_out),   32'd0);
    check("rst_hold_cnt", 32'(err_count),  32'd0);
    check("rst_hold_rdy", 32'(seg_ready),  32'd1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      seg_in     = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 15)] : 7'($urandom);
      seg_pos    = 1'($urandom);
      seg_valid  = ($urandom_range(0, 2) != 0);
      byte_ready = ($urandom_range(0, 3) == 0);
      resetn     = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
